ibr128_mode_ctrl: RTL and testbench

Block-cipher mode-of-operation controller for the IBR128 accelerator. It sits between the CSR block and the 128-bit cipher engine, and consumes the CSR outputs Enable, Encrypt, SOM, FB, plainText and IV. It applies ECB/CBC/CFB/OFB chaining, sequences one engine operation per start, and returns cipherText/cipherReady to the CSR block. Keys go from the CSR block to the engine directly and do not pass through this block.

---
 rtl/ibr128_mode_ctrl.sv | 136 +++++++++++++
 tb/tb_ibr128_mode_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ibr128_mode_ctrl.sv
// Mode-of-operation controller for the IBR128 engine: ECB/CBC/CFB/OFB chaining,
// one engine operation per rising edge of Enable, result returned to the CSR block.
module ibr128_mode_ctrl #(
    parameter int BLK_W = 128
) (
    input  logic             Clk,
    input  logic             RstN,
    input  logic             Enable,
    input  logic             Encrypt,
    input  logic [1:0]       SOM,
    input  logic             FB,
    input  logic [BLK_W-1:0] plainText,
    input  logic [BLK_W-1:0] IV,
    output logic [BLK_W-1:0] cipherText,
    output logic             cipherReady,
    output logic             eng_start,
    output logic             eng_decrypt,
    output logic [BLK_W-1:0] eng_din,
    input  logic             eng_done,
    input  logic [BLK_W-1:0] eng_dout
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {M_ECB = 2'b00, M_CBC = 2'b01, M_CFB = 2'b10, M_OFB = 2'b11} mode_t;

    state_t           r_state, w_state_next;
    mode_t            r_mode, w_mode_in;
    logic             r_en_prev, r_enc, r_ready, r_start, r_dec;
    logic [BLK_W-1:0] r_pq, r_c, r_ct, r_din;
    logic             w_enter, w_complete, w_dec_next;
    logic [BLK_W-1:0] w_chain0, w_din_next, w_out, w_c_next;

    assign w_mode_in = mode_t'(SOM);
    assign w_enter   = (r_state == S_IDLE) && Enable && !r_en_prev;
    // The engine input at start must see the chain value C is about to take.
    assign w_chain0  = FB ? r_c : IV;

    // NOTE: every signal written in always_comb gets a default first; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        w_din_next = plainText;
        w_dec_next = 1'b0;
        case (w_mode_in)
            M_ECB: w_dec_next = !Encrypt;
            M_CBC: begin
                w_din_next = Encrypt ? (plainText ^ w_chain0) : plainText;
                w_dec_next = !Encrypt;
            end
            default: w_din_next = w_chain0;
        endcase
    end

    always_comb begin
        w_out    = eng_dout ^ r_pq;
        w_c_next = r_c;
        case (r_mode)
            M_ECB: w_out = eng_dout;
            M_CBC: begin
                w_out    = r_enc ? eng_dout : (eng_dout ^ r_c);
                w_c_next = r_enc ? eng_dout : r_pq;
            end
            M_CFB:   w_c_next = r_enc ? w_out : r_pq;
            default: w_c_next = eng_dout;
        endcase
    end

    // Dropping Enable before completion aborts; it also wins over a same-cycle eng_done.
    always_comb begin
        w_state_next = r_state;
        w_complete   = 1'b0;
        case (r_state)
            S_IDLE:  if (w_enter) w_state_next = S_ISSUE;
            S_ISSUE: w_state_next = Enable ? S_WAIT : S_IDLE;
            S_WAIT: begin
                if (!Enable) begin
                    w_state_next = S_IDLE;
                end else if (eng_done) begin
                    w_state_next = S_DONE;
                    w_complete   = 1'b1;
                end
            end
            S_DONE:  if (!Enable) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            r_en_prev <= 1'b0;
            r_start   <= 1'b0;
            r_dec     <= 1'b0;
            r_din     <= '0;
            r_pq      <= '0;
            r_mode    <= M_ECB;
            r_enc     <= 1'b0;
            r_c       <= '0;
            r_ct      <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_en_prev <= Enable;
            r_start   <= w_enter;
            if (w_enter) begin
                r_pq   <= plainText;
                r_mode <= w_mode_in;
                r_enc  <= Encrypt;
                r_din  <= w_din_next;
                r_dec  <= w_dec_next;
                if (!FB) r_c <= IV;
            end
            if (w_complete) begin
                r_ct    <= w_out;
                r_c     <= w_c_next;
                r_ready <= 1'b1;
            end else if (r_state == S_DONE && !Enable) begin
                r_ready <= 1'b0;
            end
        end
    end

    assign cipherText  = r_ct;
    assign cipherReady = r_ready;
    assign eng_start   = r_start;
    assign eng_decrypt = r_dec;
    assign eng_din     = r_din;

endmodule

// File: tb/tb_ibr128_mode_ctrl.sv
// Scoreboard bench for ibr128_mode_ctrl with an inverting engine stub (done 4 cycles
// after start) and a mode-equation reference model.
module tb_ibr128_mode_ctrl;

    logic         Clk = 1'b0;
    logic         RstN, Enable, Encrypt, FB;
    logic [1:0]   SOM;
    logic [127:0] plainText, IV, cipherText, eng_din, eng_dout;
    logic         cipherReady, eng_start, eng_decrypt;
    logic         eng_done = 1'b0;

    ibr128_mode_ctrl #(.BLK_W(128)) dut (
        .Clk(Clk), .RstN(RstN), .Enable(Enable), .Encrypt(Encrypt), .SOM(SOM), .FB(FB),
        .plainText(plainText), .IV(IV), .cipherText(cipherText), .cipherReady(cipherReady),
        .eng_start(eng_start), .eng_decrypt(eng_decrypt), .eng_din(eng_din),
        .eng_done(eng_done), .eng_dout(eng_dout)
    );

    always #5 Clk = ~Clk;

    // Engine stub: output is the bitwise inverse of the input in both directions.
    logic [127:0] stub_din = '0;
    int           stub_cnt = 0;
    always @(posedge Clk) begin
        if (eng_start) begin
            stub_cnt <= 4;
            stub_din <= eng_din;
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
        end
        eng_done <= (stub_cnt == 1) && !eng_start;
    end
    assign eng_dout = eng_done ? ~stub_din : '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_starts = 0;
    int last_start_cyc = 0;
    bit prev_ready = 1'b0;
    logic [127:0] c_model = '0;
    logic [127:0] last_ct = '0;
    logic [127:0] din_q[$];
    logic [127:0] ct_q[$];
    bit           dec_q[$];

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] eng_f(input logic [127:0] x);
        return ~x;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Textbook mode equations over a single chain value.
    task automatic model(input bit enc, input logic [1:0] som, input bit fb,
                         input logic [127:0] p, input logic [127:0] iv,
                         output logic [127:0] din, output bit dec, output logic [127:0] ct);
        logic [127:0] chain, ks;
        chain = fb ? c_model : iv;
        dec   = 1'b0;
        case (som)
            2'd0: begin din = p; dec = !enc; ct = eng_f(p); end
            2'd1: begin
                if (enc) begin din = p ^ chain; ct = eng_f(din); chain = ct; end
                else begin din = p; dec = 1'b1; ct = eng_f(p) ^ chain; chain = p; end
            end
            2'd2: begin din = chain; ks = eng_f(chain); ct = ks ^ p; chain = enc ? ct : p; end
            default: begin din = chain; ks = eng_f(chain); ct = ks ^ p; chain = ks; end
        endcase
        c_model = chain;
    endtask

    // Monitor: pops the scoreboard whenever the DUT starts the engine or presents a result.
    always @(negedge Clk) begin
        if (!RstN) begin
            prev_ready = 1'b0;
        end else begin
            if (eng_start) begin
                n_starts++;
                last_start_cyc = cyc;
                if (din_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_start: got eng_start with nothing expected");
                end else begin
                    check("eng_din", eng_din, din_q.pop_front());
                    check("eng_decrypt", 128'(eng_decrypt), 128'(dec_q.pop_front()));
                end
            end
            if (cipherReady && !prev_ready) begin
                if (ct_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ready: got cipherReady with nothing expected");
                end else begin
                    check("cipherText", cipherText, ct_q.pop_front());
                    check("latency", 128'(cyc - last_start_cyc), 128'd6);
                end
            end
            prev_ready = cipherReady;
        end
    end

    task automatic run_block(input bit enc, input logic [1:0] som, input bit fb,
                             input logic [127:0] p, input logic [127:0] iv, input int hold);
        logic [127:0] din, ct;
        bit           dec;
        int           k, s0;
        @(negedge Clk);
        Encrypt = enc; SOM = som; FB = fb; plainText = p; IV = iv;
        model(enc, som, fb, p, iv, din, dec, ct);
        din_q.push_back(din);
        dec_q.push_back(dec);
        ct_q.push_back(ct);
        last_ct = ct;
        Enable = 1'b1;
        @(negedge Clk);
        // Inputs other than Enable must be ignored once the block is in flight.
        Encrypt = 1'($urandom()); SOM = 2'($urandom()); FB = 1'($urandom());
        plainText = rnd128(); IV = rnd128();
        k = 0;
        while (!cipherReady && k < 20) begin
            @(negedge Clk);
            k++;
        end
        check("ready_seen", 128'(cipherReady), 128'd1);
        if (hold > 0) begin
            s0 = n_starts;
            repeat (hold) @(negedge Clk);
            check("no_restart", 128'(n_starts), 128'(s0));
            check("ready_hold", 128'(cipherReady), 128'd1);
        end
        Enable = 1'b0;
        @(negedge Clk);
        check("ready_clear", 128'(cipherReady), 128'd0);
    endtask

    // Starts a block with FB=1 and drops Enable after wait_n falling edges
    // (1 = in ISSUE, 2..5 = in WAIT, 6 = same cycle as eng_done).
    task automatic run_abort(input bit enc, input logic [1:0] som, input logic [127:0] p,
                             input int wait_n);
        logic [127:0] din, ct, save;
        bit           dec;
        save = c_model;
        @(negedge Clk);
        Encrypt = enc; SOM = som; FB = 1'b1; plainText = p; IV = rnd128();
        model(enc, som, 1'b1, p, IV, din, dec, ct);
        c_model = save;
        din_q.push_back(din);
        dec_q.push_back(dec);
        Enable = 1'b1;
        repeat (wait_n) @(negedge Clk);
        if (wait_n == 6) check("simul_done_align", 128'(eng_done), 128'd1);
        Enable = 1'b0;
        repeat (10) @(negedge Clk);
        check("abort_ready", 128'(cipherReady), 128'd0);
        check("abort_ct_hold", cipherText, last_ct);
    endtask

    task automatic run_reset_mid_wait();
        logic [127:0] din, ct;
        bit           dec;
        @(negedge Clk);
        Encrypt = 1'b0; SOM = 2'd1; FB = 1'b1; plainText = rnd128(); IV = rnd128();
        model(1'b0, 2'd1, 1'b1, plainText, IV, din, dec, ct);
        din_q.push_back(din);
        dec_q.push_back(dec);
        Enable = 1'b1;
        repeat (3) @(negedge Clk);
        RstN = 1'b0;
        Enable = 1'b0;
        #1;
        check("rst_cipherText", cipherText, 128'd0);
        check("rst_cipherReady", 128'(cipherReady), 128'd0);
        check("rst_eng_start", 128'(eng_start), 128'd0);
        check("rst_eng_decrypt", 128'(eng_decrypt), 128'd0);
        check("rst_eng_din", eng_din, 128'd0);
        c_model = '0;
        last_ct = '0;
        repeat (2) @(negedge Clk);
        RstN = 1'b1;
        repeat (10) @(negedge Clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RstN = 1'b1; Enable = 1'b0; Encrypt = 1'b0; FB = 1'b0; SOM = 2'd0;
        plainText = '0; IV = '0;
        #2 RstN = 1'b0;
        #1;
        check("reset_cipherText", cipherText, 128'd0);
        check("reset_cipherReady", 128'(cipherReady), 128'd0);
        check("reset_eng_start", 128'(eng_start), 128'd0);
        check("reset_eng_din", eng_din, 128'd0);
        repeat (2) @(negedge Clk);
        RstN = 1'b1;

        run_block(1'b1, 2'd0, 1'b0, 128'h1, 128'h0, 0);
        check("ecb_enc_const", cipherText, ~128'h1);
        run_block(1'b1, 2'd1, 1'b0, 128'h0F, 128'hF0, 0);
        check("cbc_enc_b1_const", cipherText, ~128'hFF);
        run_block(1'b1, 2'd1, 1'b1, 128'h0, rnd128(), 0);
        check("cbc_enc_b2_const", cipherText, 128'hFF);
        run_block(1'b0, 2'd1, 1'b0, ~128'hFF, 128'hF0, 0);
        check("cbc_dec_const", cipherText, 128'h0F);
        run_block(1'b0, 2'd1, 1'b1, 128'h1234, rnd128(), 0);
        run_block(1'b1, 2'd3, 1'b0, 128'h1, 128'h0, 0);
        check("ofb_b1_const", cipherText, ~128'h1);
        run_block(1'b1, 2'd3, 1'b1, 128'h0, rnd128(), 0);
        check("ofb_b2_const", cipherText, 128'h0);
        run_block(1'b1, 2'd2, 1'b0, 128'h1, 128'h0, 0);
        check("cfb_const", cipherText, ~128'h1);

        run_block(1'b1, 2'd0, 1'b1, rnd128(), rnd128(), 20);

        run_block(1'b1, 2'd1, 1'b0, rnd128(), rnd128(), 0);
        run_abort(1'b1, 2'd1, rnd128(), 3);
        run_block(1'b1, 2'd1, 1'b1, rnd128(), rnd128(), 0);
        run_abort(1'b0, 2'd2, rnd128(), 6);
        run_block(1'b0, 2'd2, 1'b1, rnd128(), rnd128(), 0);

        run_reset_mid_wait();
        run_block(1'b1, 2'd1, 1'b1, rnd128(), rnd128(), 0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0)
                run_abort(1'($urandom()), 2'($urandom()), rnd128(), int'($urandom_range(1, 6)));
            else
                run_block(1'($urandom()), 2'($urandom()), 1'($urandom()), rnd128(), rnd128(), 0);
        end

        repeat (5) @(negedge Clk);
        check("queues_drained", 128'(din_q.size() + ct_q.size() + dec_q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
